// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment path.
// Size encodings match the load-side extender so decode can drive both units
// straight from funct3[1:0]. Also holds the FSM state type and the lane-mask
// and truncation helpers used by the lane packer.
package store_align_unit_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_e;

  // Unshifted byte-lane masks for each access size.
  localparam logic [3:0] LANE_MASK_B = 4'b0001;
  localparam logic [3:0] LANE_MASK_H = 4'b0011;
  localparam logic [3:0] LANE_MASK_W = 4'b1111;

  // Lane mask for a size; the reserved encoding yields no lanes.
  function automatic logic [3:0] size_lane_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = LANE_MASK_B;
      SZ_H:    m = LANE_MASK_H;
      SZ_W:    m = LANE_MASK_W;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Zero-extended register value truncated to the access width.
  function automatic logic [31:0] size_truncate(input logic [31:0] wdata,
                                                input logic [1:0]  size);
    logic [31:0] t;
    case (size)
      SZ_B:    t = {24'h000000, wdata[7:0]};
      SZ_H:    t = {16'h0000, wdata[15:0]};
      SZ_W:    t = wdata;
      default: t = 32'h00000000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/store_lane_packer.sv
// Combinational lane packer for stores.
// Shifts the truncated write data and its byte mask across an 8-lane window
// (two consecutive words) according to the byte offset.
// Ports:
//   off      in  2   byte offset within the word (addr[1:0])
//   size     in  2   access size encoding
//   wdata    in  32  register value
//   data64   out 64  lane-shifted data; [63:32] belongs to the next word
//   mask8    out 8   lane-shifted byte enables; [7:4] belongs to the next word
//   split    out 1   access touches the next word
//   size_bad out 1   reserved size encoding
module store_lane_packer
  import store_align_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [63:0] data64,
  output logic [7:0]  mask8,
  output logic        split,
  output logic        size_bad
);

  // Shift data and mask into lanes; anything spilling above lane 3 needs a second beat.
  always_comb begin
    data64   = {32'h00000000, size_truncate(wdata, size)} << {off, 3'b000};
    mask8    = {4'b0000, size_lane_mask(size)} << off;
    split    = (mask8[7:4] != 4'b0000);
    size_bad = (size == SZ_RSV);
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: truncates a register value to SB/SH/SW width and issues
// word-aligned memory write beats with byte enables. Stores crossing a word
// boundary become two beats (or are rejected when SPLIT_EN=0).
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_addr/req_wdata/req_size  byte address, register value, size
//   mem_valid/mem_ready          write beat handshake
//   mem_addr/mem_wdata/mem_be    word-aligned address, lane data, byte enables
//   done                         pulse after the final beat is accepted
//   err                          pulse after a rejected request
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-3:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       hi_data_q, hi_data_d;
  logic [3:0]        hi_be_q, hi_be_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [63:0]       data64_s;
  logic [7:0]        mask8_s;
  logic              split_s;
  logic              size_bad_s;
  logic              reject_s;

  store_lane_packer u_packer (
    .off      (req_addr[1:0]),
    .size     (req_size),
    .wdata    (req_wdata),
    .data64   (data64_s),
    .mask8    (mask8_s),
    .split    (split_s),
    .size_bad (size_bad_s)
  );

  // Reject reserved sizes, and boundary-crossing stores when splitting is disabled.
  always_comb begin
    reject_s = size_bad_s || (split_s && (SPLIT_EN == 1'b0));
  end

  // Next-state and beat register logic.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    hi_data_d   = hi_data_q;
    hi_be_d     = hi_be_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (reject_s) begin
            err_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = data64_s[31:0];
            mem_be_d    = mask8_s[3:0];
            // Upper half is parked until beat0 completes; zero enables mean no beat1.
            hi_data_d   = data64_s[63:32];
            hi_be_d     = mask8_s[7:4];
          end
        end else begin
          state_d = IDLE;
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (hi_be_q != 4'b0000) begin
            state_d     = BEAT1;
            // Word-granular increment wraps from the top word back to 0.
            mem_addr_d  = {mem_addr_q[ADDR_W-1:2] + WORD_STEP, 2'b00};
            mem_wdata_d = hi_data_q;
            mem_be_d    = hi_be_q;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end else begin
          state_d = BEAT0;
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          state_d = BEAT1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h00000000;
      mem_be_q    <= 4'b0000;
      hi_data_q   <= 32'h00000000;
      hi_be_q     <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      hi_data_q   <= hi_data_d;
      hi_be_q     <= hi_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: a vector table of stores with their
// expected beats, plus hand-written sequences for the no-split variant and
// for reset during a stalled second beat.
module tb_store_align_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        done, err;

  logic        ns_req_valid, ns_req_ready;
  logic [31:0] ns_req_addr, ns_req_wdata;
  logic [1:0]  ns_req_size;
  logic        ns_mem_valid, ns_mem_ready;
  logic [31:0] ns_mem_addr, ns_mem_wdata;
  logic [3:0]  ns_mem_be;
  logic        ns_done, ns_err;

  int n_checks = 0;
  int n_errors = 0;

  store_align_unit #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .done(done), .err(err)
  );

  store_align_unit #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_addr(ns_req_addr),
    .req_wdata(ns_req_wdata), .req_size(ns_req_size),
    .mem_valid(ns_mem_valid), .mem_ready(ns_mem_ready), .mem_addr(ns_mem_addr),
    .mem_wdata(ns_mem_wdata), .mem_be(ns_mem_be), .done(ns_done), .err(ns_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          stall;
    logic        is_err;
    logic        two;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endtask

  task automatic check_beat(input int idx, input string tag, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] d);
    check(idx, {tag, "_valid"}, 32'(mem_valid), 32'd1);
    check(idx, {tag, "_addr"},  mem_addr, a);
    check(idx, {tag, "_be"},    32'(mem_be), 32'(be));
    check(idx, {tag, "_data"},  mem_wdata, d);
  endtask

  // Applies one vector; entered and left at #1 after a rising edge.
  task automatic apply(input int idx, input vec_t v);
    check(idx, "ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_size  = v.size;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.is_err) begin
      check(idx, "err_pulse", 32'(err), 32'd1);
      check(idx, "err_nobeat", 32'(mem_valid), 32'd0);
      check(idx, "err_nodone", 32'(done), 32'd0);
      @(posedge clk); #1;
      check(idx, "err_clear", 32'(err), 32'd0);
      check(idx, "err_nobeat2", 32'(mem_valid), 32'd0);
    end else begin
      check(idx, "busy", 32'(req_ready), 32'd0);
      check_beat(idx, "b0", v.a0, v.be0, v.d0);
      for (int s = 0; s < v.stall; s++) begin
        @(posedge clk); #1;
        check_beat(idx, "b0_stall", v.a0, v.be0, v.d0);
      end
      mem_ready = 1'b1;
      check(idx, "b0_nodone", 32'(done), 32'd0);
      @(posedge clk); #1;
      if (v.two) begin
        check_beat(idx, "b1", v.a1, v.be1, v.d1);
        check(idx, "b1_nodone", 32'(done), 32'd0);
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      check(idx, "done", 32'(done), 32'd1);
      check(idx, "done_noerr", 32'(err), 32'd0);
      check(idx, "done_novalid", 32'(mem_valid), 32'd0);
      check(idx, "done_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      check(idx, "done_clear", 32'(done), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h00000100, 32'hDEADBEEF, 2'b10, 0, 1'b0, 1'b0,
                32'h00000100, 4'b1111, 32'hDEADBEEF, 32'h0, 4'b0, 32'h0};
    vecs[1] = '{32'h00000103, 32'h123456A5, 2'b00, 0, 1'b0, 1'b0,
                32'h00000100, 4'b1000, 32'hA5000000, 32'h0, 4'b0, 32'h0};
    vecs[2] = '{32'h00000203, 32'hFFFFBEEF, 2'b01, 0, 1'b0, 1'b1,
                32'h00000200, 4'b1000, 32'hEF000000, 32'h00000204, 4'b0001, 32'h000000BE};
    vecs[3] = '{32'hFFFFFFFE, 32'h11223344, 2'b10, 3, 1'b0, 1'b1,
                32'hFFFFFFFC, 4'b1100, 32'h33440000, 32'h00000000, 4'b0011, 32'h00001122};
    vecs[4] = '{32'h00000002, 32'hA5A5CAFE, 2'b01, 0, 1'b0, 1'b0,
                32'h00000000, 4'b1100, 32'hCAFE0000, 32'h0, 4'b0, 32'h0};
    vecs[5] = '{32'h00000001, 32'h000000FF, 2'b00, 0, 1'b0, 1'b0,
                32'h00000000, 4'b0010, 32'h0000FF00, 32'h0, 4'b0, 32'h0};
    vecs[6] = '{32'h00000005, 32'hAABBCCDD, 2'b10, 0, 1'b0, 1'b1,
                32'h00000004, 4'b1110, 32'hBBCCDD00, 32'h00000008, 4'b0001, 32'h000000AA};
    vecs[7] = '{32'h00000010, 32'h12345678, 2'b11, 0, 1'b1, 1'b0,
                32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[8] = '{32'h00000001, 32'h12345678, 2'b01, 1, 1'b0, 1'b0,
                32'h00000000, 4'b0110, 32'h00567800, 32'h0, 4'b0, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00;
    mem_ready = 1'b0;
    ns_req_valid = 1'b0; ns_req_addr = 32'h0; ns_req_wdata = 32'h0; ns_req_size = 2'b00;
    ns_mem_ready = 1'b1;

    @(posedge clk); #1;
    check(0, "rst_ready", 32'(req_ready), 32'd1);
    check(0, "rst_valid", 32'(mem_valid), 32'd0);
    check(0, "rst_addr", mem_addr, 32'h0);
    check(0, "rst_data", mem_wdata, 32'h0);
    check(0, "rst_be", 32'(mem_be), 32'd0);
    check(0, "rst_done", 32'(done), 32'd0);
    check(0, "rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      apply(i, vecs[i]);
    end

    // No-split variant: boundary-crossing SW is rejected, aligned SW still goes out.
    ns_req_valid = 1'b1; ns_req_addr = 32'h00000101; ns_req_wdata = 32'hCAFEF00D;
    ns_req_size = 2'b10;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    check(50, "ns_err", 32'(ns_err), 32'd1);
    check(50, "ns_nobeat", 32'(ns_mem_valid), 32'd0);
    check(50, "ns_nodone", 32'(ns_done), 32'd0);
    check(50, "ns_ready", 32'(ns_req_ready), 32'd1);
    @(posedge clk); #1;
    check(50, "ns_err_clear", 32'(ns_err), 32'd0);
    check(50, "ns_nobeat2", 32'(ns_mem_valid), 32'd0);
    ns_req_valid = 1'b1; ns_req_addr = 32'h00000104;
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    check(51, "ns_valid", 32'(ns_mem_valid), 32'd1);
    check(51, "ns_addr", ns_mem_addr, 32'h00000104);
    check(51, "ns_be", 32'(ns_mem_be), 32'd15);
    check(51, "ns_data", ns_mem_wdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    check(51, "ns_done", 32'(ns_done), 32'd1);
    check(51, "ns_done_noerr", 32'(ns_err), 32'd0);

    // Reset while the second beat of a split store is stalled.
    req_valid = 1'b1; req_addr = 32'h00000203; req_wdata = 32'hFFFFBEEF; req_size = 2'b01;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_beat(60, "rb0", 32'h00000200, 4'b1000, 32'hEF000000);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check_beat(60, "rb1", 32'h00000204, 4'b0001, 32'h000000BE);
    @(posedge clk); #1;
    check_beat(60, "rb1_stall", 32'h00000204, 4'b0001, 32'h000000BE);
    #1 rst = 1'b1;
    #1;
    check(60, "rst_mid_valid", 32'(mem_valid), 32'd0);
    check(60, "rst_mid_ready", 32'(req_ready), 32'd1);
    check(60, "rst_mid_be", 32'(mem_be), 32'd0);
    check(60, "rst_mid_done", 32'(done), 32'd0);
    check(60, "rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check(61, "post_rst_done", 32'(done), 32'd0);
      check(61, "post_rst_err", 32'(err), 32'd0);
      check(61, "post_rst_valid", 32'(mem_valid), 32'd0);
    end

    // Unit recovers and handles a fresh store.
    apply(62, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
